// File: rtl/lcd_frame_scheduler_if.sv
// Frame-report bus from the switch ports to the LCD frame scheduler.
//   frame_valid   : per-port one-cycle strobe, bit i = port i
//   frame_addr    : per-port address byte ([7:4] dest, [3:0] src), port i in [i]
//   frame_payload : per-port payload byte, port i in [i]
// master = switch-port side (drives), slave = scheduler side (samples).
interface lcd_frame_scheduler_if #(
  parameter int NUM_PORTS = 4
);
  logic [NUM_PORTS-1:0]       frame_valid;
  logic [NUM_PORTS-1:0][7:0]  frame_addr;
  logic [NUM_PORTS-1:0][7:0]  frame_payload;

  modport master (output frame_valid, frame_addr, frame_payload);
  modport slave  (input  frame_valid, frame_addr, frame_payload);
endinterface

// File: rtl/lcd_frame_scheduler.sv
// LCD frame scheduler: buffers one reported frame per switch port and shares
// the single text LCD among the ports round-robin, keeping each granted frame
// on the display outputs for at least HOLD_CYCLES unfrozen cycles.
// Ports:
//   clk, rst_n    : clock (shared with the LCD driver), async active-low reset
//   frm (slave)   : per-port frame strobes with address/payload bytes
//   freeze        : stalls the hold counter; capture keeps running
//   addr_out      : address byte of the displayed frame
//   payload_out   : payload byte of the displayed frame
//   disp_valid    : a frame has been shown since reset
//   cur_port      : port index of the displayed frame
//   busy          : a frame is inside its hold window
//   pending       : per-port "frame waiting" flags
//   overflow_cnt  : saturating count of frames overwritten before display

// One buffered frame for one port.
module lcd_frame_slot (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cap,         // new frame strobe from the port
  input  logic       take,        // this slot is granted this edge
  input  logic [7:0] addr_in,
  input  logic [7:0] payload_in,
  output logic [7:0] addr,
  output logic [7:0] payload,
  output logic       pending,
  output logic       lost         // a waiting frame is being overwritten
);
  // Capturing on the grant edge is not a loss: the grant reads the old
  // contents, and the new frame becomes the next pending one.
  assign lost = cap & pending & ~take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr    <= 8'h00;
      payload <= 8'h00;
      pending <= 1'b0;
    end else begin
      if (cap) begin
        addr    <= addr_in;
        payload <= payload_in;
      end
      if (cap)       pending <= 1'b1;
      else if (take) pending <= 1'b0;
    end
  end
endmodule

module lcd_frame_scheduler #(
  parameter int NUM_PORTS   = 4,
  parameter int HOLD_CYCLES = 1288,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lcd_frame_scheduler_if.slave frm,
  input  logic                 freeze,
  output logic [7:0]           addr_out,
  output logic [7:0]           payload_out,
  output logic                 disp_valid,
  output logic [1:0]           cur_port,
  output logic                 busy,
  output logic [NUM_PORTS-1:0] pending,
  output logic [7:0]           overflow_cnt
);
  typedef enum logic {IDLE, HOLD} state_t;

  state_t                    state, state_nx;
  logic [CNT_W-1:0]          hold_cnt, hold_cnt_nx;
  logic [1:0]                last_grant;
  logic [1:0]                win;
  logic                      grant;
  logic [NUM_PORTS-1:0]      take, lost;
  logic [NUM_PORTS-1:0][7:0] slot_addr, slot_payload;
  logic [2:0]                ovf_inc;
  logic [8:0]                ovf_sum;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_slot
    lcd_frame_slot u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .cap        (frm.frame_valid[i]),
      .take       (take[i]),
      .addr_in    (frm.frame_addr[i]),
      .payload_in (frm.frame_payload[i]),
      .addr       (slot_addr[i]),
      .payload    (slot_payload[i]),
      .pending    (pending[i]),
      .lost       (lost[i])
    );
  end

  // Round-robin search from last_grant+1. Scanning the farthest candidate
  // first and letting nearer hits overwrite leaves the nearest pending port.
  always_comb begin
    win = last_grant;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      if (pending[last_grant + 2'(k)]) win = last_grant + 2'(k);
    end
  end

  always_comb begin
    state_nx    = state;
    hold_cnt_nx = hold_cnt;
    grant       = 1'b0;
    case (state)
      IDLE: if (|pending) grant = 1'b1;
      HOLD: begin
        if (!freeze) begin
          if (hold_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
            if (|pending) grant = 1'b1;
            else begin
              state_nx    = IDLE;
              hold_cnt_nx = '0;
            end
          end else begin
            hold_cnt_nx = hold_cnt + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    if (grant) begin
      state_nx    = HOLD;
      hold_cnt_nx = '0;
    end
  end

  always_comb begin
    take      = '0;
    take[win] = grant;
  end

  // Several ports may lose a frame on the same edge; count each one.
  always_comb begin
    ovf_inc = '0;
    for (int i = 0; i < NUM_PORTS; i++) ovf_inc = ovf_inc + 3'(lost[i]);
    ovf_sum = {1'b0, overflow_cnt} + {6'b0, ovf_inc};
  end

  assign busy = (state == HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      last_grant   <= 2'd3;
      addr_out     <= 8'h00;
      payload_out  <= 8'h00;
      cur_port     <= 2'd0;
      disp_valid   <= 1'b0;
      overflow_cnt <= 8'h00;
    end else begin
      state        <= state_nx;
      hold_cnt     <= hold_cnt_nx;
      overflow_cnt <= ovf_sum[8] ? 8'hFF : ovf_sum[7:0];
      if (grant) begin
        addr_out    <= slot_addr[win];
        payload_out <= slot_payload[win];
        cur_port    <= win;
        last_grant  <= win;
        disp_valid  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_lcd_frame_scheduler.sv
module tb_lcd_frame_scheduler;
  localparam int HOLD = 1288;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       freeze = 1'b0;
  logic [7:0] addr_out, payload_out, overflow_cnt;
  logic       disp_valid, busy;
  logic [1:0] cur_port;
  logic [3:0] pending;

  lcd_frame_scheduler_if #(.NUM_PORTS(4)) frm ();

  lcd_frame_scheduler #(.NUM_PORTS(4), .HOLD_CYCLES(HOLD), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frm          (frm),
    .freeze       (freeze),
    .addr_out     (addr_out),
    .payload_out  (payload_out),
    .disp_valid   (disp_valid),
    .cur_port     (cur_port),
    .busy         (busy),
    .pending      (pending),
    .overflow_cnt (overflow_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: each port holds at most one waiting frame; the display
  // shows a frame for HOLD unfrozen edges, then takes the next waiting frame
  // in rotating order, or goes idle.
  logic [7:0] m_sa [4];
  logic [7:0] m_sp [4];
  logic [3:0] m_pend;
  int         m_last, m_left, m_ovf;
  bit         m_busy, m_dv;
  logic [7:0] m_addr, m_pay;
  logic [1:0] m_cur;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin m_sa[i] = 8'h00; m_sp[i] = 8'h00; end
    m_pend = 4'b0; m_last = 3; m_left = 0; m_ovf = 0;
    m_busy = 0; m_dv = 0; m_addr = 8'h00; m_pay = 8'h00; m_cur = 2'd0;
  endtask

  task automatic model_edge(input logic [3:0] v, input logic [31:0] a, input logic [31:0] p, input logic fz);
    bit g, expire;
    int w, c;
    expire = m_busy && !fz && (m_left == 1);
    g = (m_pend != 4'b0) && (!m_busy || expire);
    w = -1;
    if (g) begin
      for (int k = 1; k <= 4; k++) begin
        c = (m_last + k) % 4;
        if (w < 0 && m_pend[c]) w = c;
      end
      m_addr = m_sa[w]; m_pay = m_sp[w]; m_cur = 2'(w); m_last = w;
      m_pend[w] = 1'b0; m_dv = 1; m_busy = 1; m_left = HOLD;
    end else if (m_busy && !fz) begin
      m_left--;
      if (m_left == 0) m_busy = 0;
    end
    for (int i = 0; i < 4; i++) begin
      if (v[i]) begin
        if (m_pend[i] && m_ovf < 255) m_ovf++;
        m_sa[i] = a[8*i +: 8];
        m_sp[i] = p[8*i +: 8];
        m_pend[i] = 1'b1;
      end
    end
  endtask

  function automatic logic [31:0] dut_word();
    return {addr_out, payload_out, cur_port, busy, pending, overflow_cnt, disp_valid};
  endfunction

  function automatic logic [31:0] model_word();
    return {m_addr, m_pay, m_cur, m_busy, m_pend, 8'(m_ovf), m_dv};
  endfunction

  function automatic logic [31:0] put(input int port, input logic [7:0] b);
    return 32'(b) << (8 * port);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One clock edge with the given inputs; outputs checked against the model.
  task automatic step(input logic [3:0] v, input logic [31:0] a, input logic [31:0] p, input logic fz);
    frm.frame_valid = v; frm.frame_addr = a; frm.frame_payload = p; freeze = fz;
    @(posedge clk);
    model_edge(v, a, p, fz);
    #1;
    chk("model", dut_word(), model_word());
  endtask

  task automatic idle(input int n);
    repeat (n) step(4'b0, 32'h0, 32'h0, 1'b0);
  endtask

  // Idle edges until the displayed frame or busy changes; n = edges taken.
  task automatic wait_evt(input string nm, output int n);
    logic [18:0] prev;
    prev = {addr_out, payload_out, cur_port, busy};
    n = 0;
    do begin
      idle(1);
      n++;
    end while ({addr_out, payload_out, cur_port, busy} == prev && n < 5000);
    if (n >= 5000) begin
      vectors++; miscompares++;
      $display("FAIL %s: no display change within 5000 cycles", nm);
    end
  endtask

  task automatic do_reset(input string nm);
    #2 rst_n = 1'b0;
    #1 chk(nm, dut_word(), 32'h0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  v;
    logic [31:0] a, p;
    logic        fz;
    logic [7:0]  ea, ep;
    logic [1:0]  ec;
    logic        eb;
    logic [3:0]  epd;
    logic [7:0]  eo;
    logic        edv;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, tot;
    logic [3:0] rv;
    int fz_left;

    frm.frame_valid = '0; frm.frame_addr = '0; frm.frame_payload = '0;
    model_reset();

    tbl[0] = '{4'b0000, 32'h0, 32'h0, 1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 4'b0000, 8'd0, 1'b0};
    tbl[1] = '{4'b0010, put(1, 8'hAB), put(1, 8'h05), 1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 4'b0010, 8'd0, 1'b0};
    tbl[2] = '{4'b0000, 32'h0, 32'h0, 1'b0, 8'hAB, 8'h05, 2'd1, 1'b1, 4'b0000, 8'd0, 1'b1};
    tbl[3] = '{4'b0100, put(2, 8'h2C), put(2, 8'h11), 1'b0, 8'hAB, 8'h05, 2'd1, 1'b1, 4'b0100, 8'd0, 1'b1};
    tbl[4] = '{4'b0100, put(2, 8'h3C), put(2, 8'h22), 1'b1, 8'hAB, 8'h05, 2'd1, 1'b1, 4'b0100, 8'd1, 1'b1};
    tbl[5] = '{4'b0001, put(0, 8'h5A), put(0, 8'h66), 1'b0, 8'hAB, 8'h05, 2'd1, 1'b1, 4'b0101, 8'd1, 1'b1};

    // Reset values while held in reset.
    #2 chk("reset", dut_word(), 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // Table: single frame on port 1, then captures and an overwrite mid-hold.
    // The freeze in vector 4 stalls the hold by one edge.
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].v, tbl[i].a, tbl[i].p, tbl[i].fz);
      chk($sformatf("tbl%0d", i), dut_word(),
          {tbl[i].ea, tbl[i].ep, tbl[i].ec, tbl[i].eb, tbl[i].epd, tbl[i].eo, tbl[i].edv});
    end
    wait_evt("tbl_hold1", n);
    chk("tbl_hold1_len", n + 3, HOLD + 1);
    chk("tbl_grant2", {addr_out, payload_out, 6'(cur_port)}, {8'h3C, 8'h22, 6'd2});
    wait_evt("tbl_hold2", n);
    chk("tbl_hold2_len", n, HOLD);
    chk("tbl_grant0", {addr_out, payload_out, 6'(cur_port)}, {8'h5A, 8'h66, 6'd0});
    wait_evt("tbl_hold3", n);
    chk("tbl_hold3_len", n, HOLD);
    chk("tbl_retain", {addr_out, payload_out, 7'(busy)}, {8'h5A, 8'h66, 7'd0});

    // Round robin, back-to-back.
    do_reset("rr_reset");
    step(4'b1111, 32'h13121110, 32'h23222120, 1'b0);
    chk("rr_pend", 32'(pending), 32'hF);
    idle(1);
    chk("rr_g0", {addr_out, 6'(cur_port), 2'(busy)}, {8'h10, 6'd0, 2'd1});
    for (int j = 1; j < 4; j++) begin
      wait_evt("rr_hold", n);
      chk($sformatf("rr_len%0d", j), n, HOLD);
      chk($sformatf("rr_g%0d", j), {addr_out, payload_out, 6'(cur_port), 2'(busy)},
          {8'(8'h10 + j), 8'(8'h20 + j), 6'(j), 2'd1});
    end
    wait_evt("rr_end", n);
    chk("rr_end_len", n, HOLD);
    chk("rr_idle", 32'(busy), 32'h0);
    step(4'b1000, put(3, 8'h33), put(3, 8'h44), 1'b0);
    idle(1);
    chk("rr_p3", {addr_out, 6'(cur_port), 2'(busy)}, {8'h33, 6'd3, 2'd1});

    // Overflow and saturation.
    do_reset("ovf_reset");
    step(4'b1000, put(3, 8'h30), put(3, 8'h01), 1'b0);
    idle(1);
    step(4'b0001, put(0, 8'hA1), put(0, 8'h03), 1'b0);
    step(4'b0001, put(0, 8'hC1), put(0, 8'h07), 1'b0);
    chk("ovf_one", 32'(overflow_cnt), 32'd1);
    wait_evt("ovf_wait", n);
    chk("ovf_disp", {addr_out, payload_out, 6'(cur_port)}, {8'hC1, 8'h07, 6'd0});
    for (int k = 0; k < 300; k++) step(4'b0010, put(1, 8'(k)), put(1, 8'(k)), 1'b0);
    chk("ovf_sat", 32'(overflow_cnt), 32'hFF);

    // Same-edge grant and capture.
    do_reset("same_reset");
    step(4'b0100, put(2, 8'h2A), put(2, 8'h01), 1'b0);
    step(4'b0100, put(2, 8'h2B), put(2, 8'h02), 1'b0);
    chk("same_grant", {addr_out, payload_out, 4'(pending), overflow_cnt},
        {8'h2A, 8'h01, 4'b0100, 8'h00});
    wait_evt("same_wait", n);
    chk("same_len", n, HOLD);
    chk("same_next", {addr_out, payload_out, 6'(cur_port)}, {8'h2B, 8'h02, 6'd2});

    // Freeze mid-hold.
    do_reset("frz_reset");
    step(4'b0001, put(0, 8'h0F), put(0, 8'h0E), 1'b0);
    idle(1);
    idle(99);
    for (int k = 0; k < 500; k++) begin
      if (k == 10) begin
        step(4'b0010, put(1, 8'h1F), put(1, 8'h1E), 1'b1);
        chk("frz_pend", 32'(pending), 32'h2);
      end else begin
        step(4'b0000, 32'h0, 32'h0, 1'b1);
      end
    end
    chk("frz_busy", {addr_out, 6'(cur_port), 2'(busy)}, {8'h0F, 6'd0, 2'd1});
    wait_evt("frz_wait", n);
    tot = 99 + 500 + n;
    chk("frz_len", tot, HOLD + 500);
    chk("frz_next", {addr_out, 6'(cur_port)}, {8'h1F, 6'd1});

    // Asynchronous reset mid-hold with frames pending.
    do_reset("arst_pre");
    step(4'b0001, put(0, 8'h01), put(0, 8'h02), 1'b0);
    idle(1);
    step(4'b0110, put(1, 8'h11) | put(2, 8'h21), put(1, 8'h12) | put(2, 8'h22), 1'b0);
    chk("arst_pend", 32'(pending), 32'h6);
    do_reset("arst_mid");
    step(4'b0100, put(2, 8'h77), put(2, 8'h88), 1'b0);
    chk("arst_cap", {4'(pending), 4'(busy)}, {4'b0100, 4'd0});
    idle(1);
    chk("arst_grant", {addr_out, payload_out, 6'(cur_port), 2'(busy)}, {8'h77, 8'h88, 6'd2, 2'd1});

    // Random traffic against the model.
    do_reset("rnd_reset");
    fz_left = 0;
    for (int k = 0; k < 15000; k++) begin
      for (int i = 0; i < 4; i++) rv[i] = ($urandom_range(0, 299) == 0);
      if (fz_left > 0) fz_left--;
      else if ($urandom_range(0, 1999) == 0) fz_left = $urandom_range(1, 400);
      step(rv, $urandom, $urandom, fz_left > 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/lcd_frame_scheduler.md
Name: lcd_frame_scheduler

Overview:
- Shares the single text LCD among the four switch ports (A–D).
- Each port reports forwarded frames as a one-cycle header/payload pulse.
- The block buffers one frame per port and grants the LCD round-robin.
- It presents the granted frame's address byte and payload byte to the LCD driver for a guaranteed minimum on-screen time.

Parameters:
- NUM_PORTS, 4, number of requesting ports; fixed at 4 (port index 2 bits).
- HOLD_CYCLES, 1288, minimum clk cycles a granted frame stays on the display outputs (two full LCD refresh passes of 644 cycles).
- CNT_W, 16, hold counter width; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
- clk  in  1  system clock; same clock as the LCD driver.
- rst_n  in  1  asynchronous active-low reset.
- frame_valid  in  4  per-port one-cycle strobe, bit i = port i.
- frame_addr  in  32  per-port address byte, port i at [8i+7:8i]; [7:4] = dest, [3:0] = src.
- frame_payload  in  32  per-port payload byte, port i at [8i+7:8i].
- freeze  in  1  while high, the hold counter does not advance; the current frame stays displayed.
- addr_out  out  8  address byte to the LCD driver's address input.
- payload_out  out  8  payload byte to the LCD driver's payload input.
- disp_valid  out  1  high once at least one frame has been displayed since reset.
- cur_port  out  2  port index of the frame on addr_out/payload_out.
- busy  out  1  high in HOLD state.
- pending  out  4  per-port pending-flag status.
- overflow_cnt  out  8  saturating count of frames overwritten before display.

Behaviour:
- Reset (rst_n low, async): state IDLE.
  - addr_out=8'h00, payload_out=8'h00, cur_port=0.
  - disp_valid=0, busy=0, pending=4'b0000, overflow_cnt=0, hold counter=0.
  - last_grant=3, so port 0 has first priority.
- Capture, per port i, every clk edge where frame_valid[i]=1:
  - The slot register takes frame_addr/frame_payload slice i, and pending[i] is set.
  - If pending[i] was already 1 and not granted this same edge, the old frame is lost and overflow_cnt increments, saturating at 8'hFF.
- Arbitration: round-robin search starting at (last_grant+1) mod 4 and wrapping. The winner w is the first port with pending[w]=1.
- The grant action, on the same edge:
  - addr_out/payload_out load slot w; cur_port=w; last_grant=w.
  - pending[w] clears; disp_valid=1; hold counter=0; state goes to HOLD.
- Same-edge grant and new frame_valid[w]: the grant uses the old slot contents. The new frame is written to the slot and pending[w] stays 1. This is not an overflow.
- State machine:
  - IDLE: busy=0. If any pending bit is set, grant and go to HOLD; otherwise stay. Outputs keep the last frame shown.
  - HOLD: busy=1. If freeze=0, the counter increments. When counter==HOLD_CYCLES-1 and freeze=0:
    - if any pending bit is set, grant directly (back-to-back, HOLD to HOLD, counter=0);
    - otherwise go to IDLE.
  - freeze=1 stalls the counter at its current value. Capture, pending and overflow continue normally.
- Latency:
  - frame_valid sampled at edge k sets pending at edge k.
  - An IDLE grant occurs at edge k+1, so addr_out is updated after edge k+1.
  - Each grant holds its outputs exactly HOLD_CYCLES edges, or longer while frozen.
- Fairness: with all four ports continuously pending, grant order is 0,1,2,3,0,… with one grant per HOLD_CYCLES.
- addr_out/payload_out change only on a grant edge or reset; they are never glitched by capture.
- Reset mid-HOLD: immediate return to the reset values. All pending frames are discarded.

Test Plan:
- Reset: assert rst_n=0 mid-HOLD with pending=4'b0110 → all outputs at reset values asynchronously; after release, first frame_valid on port 2 is granted 1 edge after capture (cur_port=2).
- Single frame: port 1 strobes addr 8'hAB, payload 8'h05 at edge k → addr_out=8'hAB, payload_out=8'h05, cur_port=1, busy=1 after edge k+1; busy falls exactly 1288 edges later; outputs retained in IDLE.
- Round-robin: ports 0–3 strobe together → grants in order 0,1,2,3, each held 1288 cycles back-to-back with no IDLE cycle between; last_grant=3 then next lone strobe on port 3 is granted immediately.
- Overflow: port 0 strobes twice (8'hA1/3 then 8'hC1/7) while port 3 is being held → overflow_cnt=1, port 0 later displays 8'hC1/7; 300 such overwrites → overflow_cnt saturates at 8'hFF.
- Same-edge grant/capture: port 2 strobes new frame on the grant edge of its pending frame → old frame displayed, pending[2] remains 1, overflow_cnt unchanged, new frame displayed next.
- Freeze: assert freeze for 500 cycles mid-HOLD → busy high for 1288+500 cycles total; captures during freeze still set pending.
